// File: rtl/dht_sched.sv
// dht_sched: DHT11 read sequencer (inter-read gap, watchdog, checksum, retries, offset correction, 2-consumer req/ack).
// req is a level held until the one-cycle ack; `define DHT_SCHED_AUTO_EN adds periodic autonomous reads.
module dht_sched #(
  parameter int unsigned MIN_GAP_CYC = 50000000,
  parameter int unsigned AUTO_CYC    = 25000000,
  parameter int unsigned WDOG_CYC    = 1500000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned HUM_OFS     = 40,
  parameter int unsigned TEMP_OFS    = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  output logic [1:0]  o_ack,
  output logic        o_rd_start,
  input  logic        i_rd_done,
  input  logic        i_rd_err,
  input  logic [39:0] i_rd_data,
  output logic [7:0]  o_hum,
  output logic [7:0]  o_temp,
  output logic        o_data_valid,
  output logic        o_fail,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  localparam int GW = (MIN_GAP_CYC > 0) ? $clog2(MIN_GAP_CYC + 1) : 1;
  localparam int WW = (WDOG_CYC > 0) ? $clog2(WDOG_CYC + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP_CYC);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_CYC);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    HUM_SUB   = 8'(HUM_OFS);
  localparam logic [7:0]    TMP_SUB   = 8'(TEMP_OFS);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_START, S_WAIT, S_CHECK, S_UPDATE, S_FAIL
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [GW-1:0]   r_gap;
  logic [WW-1:0]   r_wdog;
  logic [RW-1:0]   r_retry;
  logic [1:0]      r_mask;
  logic            r_rr;
  logic [39:0]     r_frame;
  logic [7:0]      r_hum;
  logic [7:0]      r_temp;
  logic [7:0]      r_err_cnt;
  logic            r_valid;
  logic            r_fail;
  logic            w_grant;
  logic            w_auto_fire;
  logic            w_chk_ok;
  logic            w_retry_left;
  logic            w_final_fail;
  logic [7:0]      w_sum;
  logic [7:0]      w_hum_cor;
  logic [7:0]      w_tmp_cor;

  assign w_sum        = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
  assign w_chk_ok     = (w_sum == r_frame[7:0]);
  assign w_hum_cor    = (r_frame[39:32] > HUM_SUB) ? (r_frame[39:32] - HUM_SUB) : 8'd0;
  assign w_tmp_cor    = (r_frame[23:16] > TMP_SUB) ? (r_frame[23:16] - TMP_SUB) : 8'd0;
  assign w_retry_left = (r_retry < RETRY_MAX);
  assign w_final_fail = (r_state == S_FAIL) && !w_retry_left;

  assign o_ack        = ((r_state == S_UPDATE) || w_final_fail) ? r_mask : 2'b00;
  assign o_rd_start   = (r_state == S_START);
  assign o_busy       = (r_state != S_IDLE);
  assign o_hum        = r_hum;
  assign o_temp       = r_temp;
  assign o_data_valid = r_valid;
  assign o_fail       = r_fail;
  assign o_err_cnt    = r_err_cnt;

`ifdef DHT_SCHED_AUTO_EN
  localparam int AW = (AUTO_CYC > 0) ? $clog2(AUTO_CYC + 1) : 1;
  localparam logic [AW-1:0] AUTO_MAX = AW'(AUTO_CYC);
  logic [AW-1:0] r_auto;

  assign w_auto_fire = (r_auto >= AUTO_MAX);

  // A request in the same cycle wins the grant and restarts the period as well.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_auto <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_grant) r_auto <= '0;
      else         r_auto <= r_auto + 1'b1;
    end
  end
`else
  // Autonomous reads compiled out; AUTO_CYC is accepted but has no effect.
  assign w_auto_fire = (AUTO_CYC == 0) & 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((i_req != 2'b00) || w_auto_fire) begin
          w_grant = 1'b1;
          w_next  = S_GAP;
        end
      end
      S_GAP:    if (r_gap >= GAP_MAX) w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT: begin
        if (i_rd_done)                          w_next = S_CHECK;
        else if (i_rd_err || r_wdog >= WDOG_MAX) w_next = S_FAIL;
      end
      S_CHECK:  w_next = w_chk_ok ? S_UPDATE : S_FAIL;
      S_UPDATE: w_next = S_IDLE;
      S_FAIL:   w_next = w_retry_left ? S_GAP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Gap counter free-runs in every state so time spent idle counts toward the sensor rest period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gap  <= GAP_MAX;
      r_wdog <= '0;
    end else begin
      if (r_state == S_START)     r_gap <= '0;
      else if (r_gap < GAP_MAX)   r_gap <= r_gap + 1'b1;
      if (r_state == S_START)                          r_wdog <= '0;
      else if ((r_state == S_WAIT) && (r_wdog < WDOG_MAX)) r_wdog <= r_wdog + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_mask    <= 2'b00;
      r_rr      <= 1'b0;
      r_frame   <= '0;
      r_hum     <= 8'd0;
      r_temp    <= 8'd0;
      r_valid   <= 1'b0;
      r_fail    <= 1'b0;
      r_err_cnt <= 8'd0;
      r_retry   <= '0;
    end else begin
      r_state <= w_next;
      // Both requesters are served together, so the pointer only matters for future tie-break policies.
      if (w_grant) begin
        r_mask <= i_req;
        r_rr   <= ~r_rr;
      end
      if ((r_state == S_WAIT) && i_rd_done) r_frame <= i_rd_data;
      if (r_state == S_UPDATE) begin
        r_hum   <= w_hum_cor;
        r_temp  <= w_tmp_cor;
        r_valid <= 1'b1;
        r_fail  <= 1'b0;
        r_retry <= '0;
      end
      if (r_state == S_FAIL) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        if (w_retry_left) begin
          r_retry <= r_retry + 1'b1;
        end else begin
          r_fail  <= 1'b1;
          r_retry <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht_sched.sv
// Bench for dht_sched: scripted reader responder, transaction-level outcome model, per-cycle output compare.
// Parameters shrunk to MIN_GAP_CYC=100, WDOG_CYC=50.
module tb_dht_sched;
  localparam int MIN_GAP  = 100;
  localparam int WDOG     = 50;
  localparam int MAXR     = 3;
  localparam int HOFS     = 40;
  localparam int TOFS     = 7;
  localparam int K_DONE   = 0;
  localparam int K_ERR    = 1;
  localparam int K_SILENT = 2;
  localparam int K_BOTH   = 3;

  typedef struct {
    int          kind;
    int          dly;
    logic [39:0] frame;
  } att_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic        rd_done = 1'b0;
  logic        rd_err = 1'b0;
  logic [39:0] rd_data = '0;
  logic [1:0]  ack;
  logic        rd_start;
  logic [7:0]  hum;
  logic [7:0]  temp;
  logic        data_valid;
  logic        fail;
  logic        busy;
  logic [7:0]  err_cnt;

  dht_sched #(
    .MIN_GAP_CYC(MIN_GAP), .AUTO_CYC(1000), .WDOG_CYC(WDOG),
    .MAX_RETRY(MAXR), .HUM_OFS(HOFS), .TEMP_OFS(TOFS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ack(ack), .o_rd_start(rd_start),
    .i_rd_done(rd_done), .i_rd_err(rd_err), .i_rd_data(rd_data),
    .o_hum(hum), .o_temp(temp), .o_data_valid(data_valid), .o_fail(fail),
    .o_busy(busy), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_hum = 0, exp_temp = 0, exp_valid = 0, exp_fail = 0, exp_err = 0, exp_mask = 0;
  int starts_in_txn = 0, first_start = -1, last_start = -1, ack_cnt = 0;
  int last_ack = 0, txn_req_cyc = 0;

  att_t script[$];
  att_t atts[4];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_rd_start"}, int'(rd_start), 0);
    chk({tag, "_hum"}, int'(hum), 0);
    chk({tag, "_temp"}, int'(temp), 0);
    chk({tag, "_valid"}, int'(data_valid), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  function automatic bit frame_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic int sub_sat(input int v, input int ofs);
    return (v > ofs) ? v - ofs : 0;
  endfunction

  function automatic logic [39:0] mk_frame(input int h, input int hd, input int t, input int td, input bit good);
    logic [7:0] s;
    s = 8'((h + hd + t + td) % 256);
    if (!good) s = s + 8'($urandom_range(1, 255));
    return {8'(h), 8'(hd), 8'(t), 8'(td), s};
  endfunction

  function automatic att_t mk_att(input int k, input int d, input logic [39:0] f);
    att_t a;
    a.kind = k;
    a.dly = d;
    a.frame = f;
    return a;
  endfunction

  // Reader stand-in: each rd_start consumes the next scripted attempt.
  initial begin : responder
    att_t cur;
    int   cnt;
    bit   pend;
    pend = 1'b0;
    cnt = 0;
    cur = mk_att(K_SILENT, 1, '0);
    forever begin
      @(negedge clk);
      rd_done = 1'b0;
      rd_err  = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            if (cur.kind == K_DONE || cur.kind == K_BOTH) begin
              rd_done = 1'b1;
              rd_data = cur.frame;
            end
            if (cur.kind == K_ERR || cur.kind == K_BOTH) rd_err = 1'b1;
          end
        end
        if (rd_start && script.size() > 0) begin
          cur = script.pop_front();
          if (cur.kind != K_SILENT) begin
            pend = 1'b1;
            cnt = cur.dly;
          end
        end
      end
    end
  end

  // Compare process: rd_start spacing, ack mask, and published values whenever idle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        last_start = -1;
      end else begin
        if (rd_start) begin
          if (last_start >= 0) chk_rng("rd_start_spacing", cyc - last_start, MIN_GAP, 1000000);
          if (starts_in_txn == 0) first_start = cyc;
          starts_in_txn++;
          last_start = cyc;
        end
        if (ack != 2'b00) begin
          ack_cnt++;
          chk("ack_mask", int'(ack), exp_mask);
        end
        if (!busy) begin
          chk("idle_hum", int'(hum), exp_hum);
          chk("idle_temp", int'(temp), exp_temp);
          chk("idle_valid", int'(data_valid), exp_valid);
          chk("idle_fail", int'(fail), exp_fail);
          chk("idle_err_cnt", int'(err_cnt), exp_err);
          chk("idle_ack", int'(ack), 0);
          chk("idle_rd_start", int'(rd_start), 0);
        end
      end
    end
  end

  task automatic run_txn(input logic [1:0] mask, input bit lat_chk, input int drop_at);
    int n_exp, fails, got, ack_c;
    bit ok;
    n_exp = 0; fails = 0; ok = 1'b0; got = 0; ack_c = 0;
    for (int i = 0; i <= MAXR; i++) begin
      if (!ok) begin
        n_exp++;
        if ((atts[i].kind == K_DONE || atts[i].kind == K_BOTH) && frame_ok(atts[i].frame)) ok = 1'b1;
        else fails++;
      end
    end
    script.delete();
    for (int i = 0; i <= MAXR; i++) script.push_back(atts[i]);
    exp_mask = int'(mask);
    starts_in_txn = 0;
    ack_cnt = 0;
    first_start = -1;
    req = mask;
    txn_req_cyc = cyc;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge clk);
      if (drop_at > 0 && cyc == txn_req_cyc + drop_at) req = 2'b00;
      if (ack != 2'b00) begin
        got = 1;
        last_ack = int'(ack);
        ack_c = cyc;
      end
    end
    req = 2'b00;
    chk("ack_seen", got, 1);
    if (got == 1) begin
      exp_err = (exp_err + fails > 255) ? 255 : exp_err + fails;
      if (ok) begin
        exp_hum   = sub_sat(int'(atts[n_exp-1].frame[39:32]), HOFS);
        exp_temp  = sub_sat(int'(atts[n_exp-1].frame[23:16]), TOFS);
        exp_valid = 1;
        exp_fail  = 0;
      end else begin
        exp_fail = 1;
      end
      @(negedge clk);
      chk("start_count", starts_in_txn, n_exp);
      chk("ack_pulses", ack_cnt, 1);
      if (lat_chk) chk("start_latency", first_start - txn_req_cyc, 2);
      if (!ok && atts[MAXR].kind == K_SILENT) chk_rng("wdog_expiry", ack_c - last_start, WDOG, WDOG + 4);
    end
    script.delete();
  endtask

  initial begin : global_guard
    #8000000;
    $display("FAIL global_timeout: simulation did not finish, got no summary, expected finish");
    $fatal(1);
  end

  initial begin : driver
    int r, kind, h, hd, tp, td, drop;
    bit good, seen;
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic read
    atts[0] = mk_att(K_DONE, 5, {8'd75, 8'd0, 8'd30, 8'd0, 8'd105});
    for (int i = 1; i <= MAXR; i++) atts[i] = mk_att(K_SILENT, 1, '0);
    run_txn(2'b01, 1'b1, 0);
    chk("lit_basic_hum", int'(hum), 35);
    chk("lit_basic_temp", int'(temp), 23);
    chk("lit_basic_valid", int'(data_valid), 1);
    chk("lit_basic_ack", last_ack, 1);
    chk("lit_basic_err", int'(err_cnt), 0);

    // Offset saturation
    atts[0] = mk_att(K_DONE, 4, {8'd20, 8'd0, 8'd5, 8'd0, 8'd25});
    run_txn(2'b10, 1'b0, 0);
    chk("lit_sat_hum", int'(hum), 0);
    chk("lit_sat_temp", int'(temp), 0);

    // Checksum off by one, then good frame
    atts[0] = mk_att(K_DONE, 6, {8'd75, 8'd0, 8'd30, 8'd0, 8'd106});
    atts[1] = mk_att(K_DONE, 9, {8'd60, 8'd5, 8'd20, 8'd3, 8'd88});
    run_txn(2'b01, 1'b0, 0);
    chk("lit_retry_err", int'(err_cnt), 1);
    chk("lit_retry_fail", int'(fail), 0);
    chk("lit_retry_hum", int'(hum), 20);
    chk("lit_retry_temp", int'(temp), 13);

    // Silent reader: watchdog on every attempt
    for (int i = 0; i <= MAXR; i++) atts[i] = mk_att(K_SILENT, 1, '0);
    run_txn(2'b01, 1'b0, 0);
    chk("lit_wdog_starts", starts_in_txn, 4);
    chk("lit_wdog_err", int'(err_cnt), 5);
    chk("lit_wdog_fail", int'(fail), 1);
    chk("lit_wdog_hum", int'(hum), 20);
    chk("lit_wdog_temp", int'(temp), 13);

    // rd_err, then rd_done and rd_err together (done wins)
    atts[0] = mk_att(K_ERR, 3, '0);
    atts[1] = mk_att(K_BOTH, 7, {8'd50, 8'd1, 8'd27, 8'd2, 8'd80});
    run_txn(2'b10, 1'b0, 0);
    chk("lit_both_err", int'(err_cnt), 6);
    chk("lit_both_fail", int'(fail), 0);
    chk("lit_both_hum", int'(hum), 10);

    // Offset boundaries: exactly at offset and one above
    atts[0] = mk_att(K_DONE, 2, {8'd41, 8'd0, 8'd7, 8'd0, 8'd48});
    run_txn(2'b01, 1'b0, 0);
    chk("lit_edge_hum", int'(hum), 1);
    chk("lit_edge_temp", int'(temp), 0);

    // Both consumers at once, then an immediate follow-up that must wait for the gap
    atts[0] = mk_att(K_DONE, 5, {8'd45, 8'd0, 8'd10, 8'd0, 8'd55});
    run_txn(2'b11, 1'b0, 0);
    chk("lit_dual_ack", last_ack, 3);
    atts[0] = mk_att(K_DONE, 5, {8'd90, 8'd0, 8'd40, 8'd0, 8'd130});
    run_txn(2'b10, 1'b0, 0);
    chk_rng("gap_delay", first_start - txn_req_cyc, 3, MIN_GAP + 4);
    chk("lit_follow_hum", int'(hum), 50);

    // Asynchronous reset in the middle of WAIT
    script.delete();
    script.push_back(mk_att(K_SILENT, 1, '0));
    exp_mask = 1;
    req = 2'b01;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (rd_start) seen = 1'b1;
    end
    chk("rst_test_start_seen", int'(seen), 1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    exp_hum = 0; exp_temp = 0; exp_valid = 0; exp_fail = 0; exp_err = 0;
    script.delete();
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    atts[0] = mk_att(K_DONE, 5, {8'd75, 8'd0, 8'd30, 8'd0, 8'd105});
    for (int i = 1; i <= MAXR; i++) atts[i] = mk_att(K_SILENT, 1, '0);
    run_txn(2'b01, 1'b1, 0);
    chk("lit_post_rst_err", int'(err_cnt), 0);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i <= MAXR; i++) begin
        r  = int'($urandom_range(0, 99));
        h  = int'($urandom_range(0, 120));
        hd = int'($urandom_range(0, 9));
        tp = int'($urandom_range(0, 60));
        td = int'($urandom_range(0, 9));
        good = 1'b1;
        if (r < 50)      kind = K_DONE;
        else if (r < 65) begin kind = K_DONE; good = 1'b0; end
        else if (r < 80) kind = K_ERR;
        else if (r < 90) kind = K_SILENT;
        else begin kind = K_BOTH; good = ($urandom_range(0, 3) != 0); end
        atts[i] = mk_att(kind, int'($urandom_range(1, 40)), mk_frame(h, hd, tp, td, good));
      end
      drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 60)) : 0;
      run_txn(2'($urandom_range(1, 3)), 1'b0, drop);
    end

    // Drive err_cnt into saturation
    for (int t = 0; t < 64; t++) begin
      for (int i = 0; i <= MAXR; i++) atts[i] = mk_att(K_ERR, 1, '0);
      run_txn(2'b01, 1'b0, 0);
    end
    chk("lit_err_sat", int'(err_cnt), 255);
    chk("lit_err_sat_fail", int'(fail), 1);
    atts[0] = mk_att(K_DONE, 3, {8'd70, 8'd0, 8'd25, 8'd0, 8'd95});
    run_txn(2'b10, 1'b0, 0);
    chk("lit_sat_recover_fail", int'(fail), 0);
    chk("lit_sat_recover_err", int'(err_cnt), 255);
    chk("lit_sat_recover_hum", int'(hum), 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
